// File: rtl/centroid_accumulator_if.sv
// Request/response bus between centroid_accumulator (master) and the shared
// sequential divider (slave).
interface centroid_accumulator_if #(
    parameter int DIV_WIDTH = 13
);
    logic                 div_start;
    logic                 div_sign;
    logic [DIV_WIDTH-1:0] div_dividend;
    logic [DIV_WIDTH-1:0] div_divisor;
    logic [DIV_WIDTH-1:0] div_quotient;
    logic                 div_ready;

    modport master (
        output div_start, div_sign, div_dividend, div_divisor,
        input  div_quotient, div_ready
    );

    modport slave (
        input  div_start, div_sign, div_dividend, div_divisor,
        output div_quotient, div_ready
    );
endinterface

// File: rtl/centroid_accumulator.sv
// Frame centroid engine: sums hit-pixel coordinates per frame, then divides by the hit
// count on the shared divider. Define CENTROID_ROUND_EN for round-to-nearest quotients.
module centroid_accumulator #(
    parameter int COORD_WIDTH = 11,
    parameter int CNT_WIDTH   = 19,
    parameter int SUM_WIDTH   = 28,
    parameter int DIV_WIDTH   = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pixel_valid_i,
    input  logic                   pixel_hit_i,
    input  logic [COORD_WIDTH-1:0] x_i,
    input  logic [COORD_WIDTH-1:0] y_i,
    input  logic                   frame_end_i,
    centroid_accumulator_if.master div_if,
    output logic [COORD_WIDTH-1:0] cx_o,
    output logic [COORD_WIDTH-1:0] cy_o,
    output logic                   found_o,
    output logic                   result_valid_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    typedef enum logic [2:0] {
        IDLE, NORM_X, START_X, WAIT_X, NORM_Y, START_Y, WAIT_Y, DONE
    } state_e;

`ifdef CENTROID_ROUND_EN
    localparam logic ROUND = 1'b1;
`else
    localparam logic ROUND = 1'b0;
`endif

    state_e                 state_q, state_d;
    logic [SUM_WIDTH-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]   snap_y_q, snap_y_d;
    logic [CNT_WIDTH-1:0]   snap_cnt_q, snap_cnt_d;
    logic [SUM_WIDTH-1:0]   num_q, num_d;
    logic [CNT_WIDTH-1:0]   den_q, den_d;
    logic [DIV_WIDTH-1:0]   dividend_q, dividend_d, divisor_q, divisor_d;
    logic [COORD_WIDTH-1:0] qx_q, qx_d, cx_q, cx_d, cy_q, cy_d;
    logic                   found_q, found_d, overrun_q, overrun_d;

    logic                   hit;
    logic [SUM_WIDTH-1:0]   tot_x, tot_y;
    logic [CNT_WIDTH-1:0]   tot_cnt;
    logic                   need_shift;
    logic                   unused_quot_bits;

    // Adding half the count before dividing turns truncation into round-half-up.
    function automatic logic [SUM_WIDTH-1:0] seed_num(input logic [SUM_WIDTH-1:0] snap,
                                                      input logic [CNT_WIDTH-1:0] cnt);
        return snap + (ROUND ? SUM_WIDTH'(cnt >> 1) : '0);
    endfunction

    assign hit        = pixel_valid_i & pixel_hit_i;
    assign tot_x      = sum_x_q + (hit ? SUM_WIDTH'(x_i) : '0);
    assign tot_y      = sum_y_q + (hit ? SUM_WIDTH'(y_i) : '0);
    assign tot_cnt    = cnt_q + CNT_WIDTH'(hit);
    assign need_shift = (|num_q[SUM_WIDTH-1:DIV_WIDTH]) || (|den_q[CNT_WIDTH-1:DIV_WIDTH]);

    // Coordinates fit in COORD_WIDTH, so the quotient's top bits are always zero.
    assign unused_quot_bits = ^div_if.div_quotient[DIV_WIDTH-1:COORD_WIDTH];

    assign div_if.div_start    = (state_q == START_X) || (state_q == START_Y);
    assign div_if.div_sign     = 1'b0;
    assign div_if.div_dividend = dividend_q;
    assign div_if.div_divisor  = divisor_q;
    assign cx_o                = cx_q;
    assign cy_o                = cy_q;
    assign found_o             = found_q;
    assign result_valid_o      = (state_q == DONE);
    assign busy_o              = (state_q != IDLE);
    assign overrun_o           = overrun_q;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path leaves a variable
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        sum_x_d    = tot_x;
        sum_y_d    = tot_y;
        cnt_d      = tot_cnt;
        snap_y_d   = snap_y_q;
        snap_cnt_d = snap_cnt_q;
        num_d      = num_q;
        den_d      = den_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        qx_d       = qx_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        found_d    = found_q;
        overrun_d  = frame_end_i && (state_q != IDLE);

        if (frame_end_i) begin
            sum_x_d = '0;
            sum_y_d = '0;
            cnt_d   = '0;
        end

        case (state_q)
            IDLE: begin
                if (frame_end_i) begin
                    snap_y_d   = tot_y;
                    snap_cnt_d = tot_cnt;
                    num_d      = seed_num(tot_x, tot_cnt);
                    den_d      = tot_cnt;
                    state_d    = NORM_X;
                end
            end
            NORM_X, NORM_Y: begin
                if (state_q == NORM_X && snap_cnt_q == '0) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    found_d = 1'b0;
                    state_d = DONE;
                end else if (need_shift) begin
                    // Scaling both operands together keeps the ratio while fitting the divider.
                    num_d = num_q >> 1;
                    den_d = den_q >> 1;
                end else begin
                    dividend_d = num_q[DIV_WIDTH-1:0];
                    divisor_d  = den_q[DIV_WIDTH-1:0];
                    state_d    = (state_q == NORM_X) ? START_X : START_Y;
                end
            end
            START_X: state_d = WAIT_X;
            START_Y: state_d = WAIT_Y;
            WAIT_X: begin
                if (div_if.div_ready) begin
                    qx_d    = div_if.div_quotient[COORD_WIDTH-1:0];
                    num_d   = seed_num(snap_y_q, snap_cnt_q);
                    den_d   = snap_cnt_q;
                    state_d = NORM_Y;
                end
            end
            WAIT_Y: begin
                if (div_if.div_ready) begin
                    cx_d    = qx_q;
                    cy_d    = div_if.div_quotient[COORD_WIDTH-1:0];
                    found_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is written only with non-blocking assignments so every
    // register samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here, including snapshots and work registers, is reset so a
        // reset mid-division leaves no stale operands or results behind.
        if (reset) begin
            sum_x_q    <= '0;
            sum_y_q    <= '0;
            cnt_q      <= '0;
            snap_y_q   <= '0;
            snap_cnt_q <= '0;
            num_q      <= '0;
            den_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            qx_q       <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            found_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sum_x_q    <= sum_x_d;
            sum_y_q    <= sum_y_d;
            cnt_q      <= cnt_d;
            snap_y_q   <= snap_y_d;
            snap_cnt_q <= snap_cnt_d;
            num_q      <= num_d;
            den_q      <= den_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            qx_q       <= qx_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            found_q    <= found_d;
            overrun_q  <= overrun_d;
        end
    end

endmodule
